// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci generator/checker pair.
package fib_pkg;

    typedef enum logic [2:0] {
        START  = 3'd0,
        SECOND = 3'd1,
        RUN    = 3'd2,
        RESYNC = 3'd3,
        ERR    = 3'd4,
        DONE   = 3'd5
    } fib_state_e;

    localparam int FIB_WIDTH_DEF = 32;
    localparam int FIB_CNT_W_DEF = 16;
    localparam int FIB_SEED0     = 0;
    localparam int FIB_SEED1     = 1;

endpackage

// File: rtl/fib_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module fib_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/fibonacci_checker.sv
// Sink-side Fibonacci stream checker with match/mismatch/overflow reporting.
// Optional FIB_CHECKER_RESYNC_EN: re-lock onto the incoming stream after a mismatch.
module fibonacci_checker
    import fib_pkg::*;
#(
    parameter int               WIDTH = FIB_WIDTH_DEF,
    parameter int               CNT_W = FIB_CNT_W_DEF,
    parameter logic [WIDTH-1:0] SEED0 = WIDTH'(FIB_SEED0),
    parameter logic [WIDTH-1:0] SEED1 = WIDTH'(FIB_SEED1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seq_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             clear_i,
    output logic [WIDTH-1:0] exp_o,
    output logic             match_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_idx_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o,
    output fib_state_e       state_o
);

    // Handshake: a term is consumed on any rising edge where valid_i & ready_o.
    // ready_o depends on state only, so there is no combinational valid->ready path.

    fib_state_e       state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [WIDTH-1:0] exp_q, exp_nxt;
    logic             err_nxt, match_nxt, ovf_nxt;
    logic [CNT_W-1:0] err_idx_nxt;
    logic             xfer, is_eq;
    logic [WIDTH:0]   sum, resync_sum;

`ifdef FIB_CHECKER_RESYNC_EN
    assign ready_o = (state != DONE);
`else
    assign ready_o = (state != ERR) && (state != DONE);
`endif

    assign xfer       = valid_i & ready_o;
    assign is_eq      = (seq_i == exp_q);
    assign sum        = {1'b0, prev} + {1'b0, exp_q};
    assign resync_sum = {1'b0, prev} + {1'b0, seq_i};

    assign exp_o   = exp_q;
    assign state_o = state;

    always_comb begin
        state_nxt   = state;
        prev_nxt    = prev;
        exp_nxt     = exp_q;
        err_nxt     = err_o;
        err_idx_nxt = err_idx_o;
        ovf_nxt     = ovf_o;
        match_nxt   = 1'b0;
        if (xfer) begin
            case (state)
                START: begin
                    prev_nxt  = SEED0;
                    exp_nxt   = SEED1;
                    state_nxt = SECOND;
                end
                SECOND, RUN: begin
                    prev_nxt  = exp_q;
                    exp_nxt   = sum[WIDTH-1:0];
                    state_nxt = sum[WIDTH] ? DONE : RUN;
                    ovf_nxt   = ovf_o | sum[WIDTH];
                end
`ifdef FIB_CHECKER_RESYNC_EN
                // Unchecked term: it becomes the new current term of the sequence.
                RESYNC: begin
                    prev_nxt  = seq_i;
                    exp_nxt   = resync_sum[WIDTH-1:0];
                    state_nxt = resync_sum[WIDTH] ? DONE : RUN;
                    ovf_nxt   = ovf_o | resync_sum[WIDTH];
                end
`endif
                default: ;
            endcase
            if (state != RESYNC) begin
                match_nxt = is_eq;
                if (!is_eq) begin
                    if (!err_o) begin
                        err_nxt     = 1'b1;
                        err_idx_nxt = count_o;
                    end
                    // exp_o keeps the value that failed to match.
                    exp_nxt = exp_q;
`ifdef FIB_CHECKER_RESYNC_EN
                    prev_nxt  = seq_i;
                    ovf_nxt   = ovf_o;
                    state_nxt = RESYNC;
`else
                    prev_nxt  = prev;
                    state_nxt = ERR;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            state     <= START;
            prev      <= '0;
            exp_q     <= SEED0;
            err_o     <= 1'b0;
            err_idx_o <= '0;
            match_o   <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            exp_q     <= exp_nxt;
            err_o     <= err_nxt;
            err_idx_o <= err_idx_nxt;
            match_o   <= match_nxt;
            ovf_o     <= ovf_nxt;
        end
    end

    fib_sat_counter #(.CNT_W(CNT_W)) u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_i),
        .inc   (xfer),
        .q     (count_o)
    );

endmodule
